instr_fetch_queue: RTL and testbench

- Fetch front end for the pipelined RISC core; sits directly upstream of the decode/execute stage.
- Generates sequential instruction-memory read requests from its own PC.
- Buffers returned instruction words, each tagged with its address, in a DEPTH-entry FIFO.
- Presents the head word to execute via a valid/ready handshake; execute redirects it on taken BRA; fetch_en low (HLT) stops new requests.

---
 rtl/instr_fetch_queue.sv | 96 +++++++++
 tb/tb_instr_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential imem reads from pc; in-order responses are tagged with their address and queued.
// Response to ir_valid takes 1 cycle; issue is credit-limited by count+outstanding, and ir_ready stalls dequeue.
module instr_fetch_queue #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12,
  parameter int DEPTH    = 4,
  parameter logic [ADDRSIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_en,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDRSIZE-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [WIDTH-1:0]    imem_rsp_data,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [WIDTH-1:0]    ir_data,
  output logic [ADDRSIZE-1:0] ir_pc,
  input  logic                redirect_valid,
  input  logic [ADDRSIZE-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Issue ignores drop, so repeated redirects can pile up more stale responses than DEPTH.
  localparam int DW = CW + 2;

  typedef struct packed {
    logic [ADDRSIZE-1:0] pc;
    logic [WIDTH-1:0]    dat;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [ADDRSIZE-1:0] pc;
  logic [ADDRSIZE-1:0] rsp_pc;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       outstanding;
  logic [DW-1:0]       drop;
  logic                credit_ok;
  logic                req_fire;
  logic                rsp_keep;
  logic                push;
  logic                pop;

  assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = reset_n && fetch_en && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop == '0);
  assign push     = rsp_keep && !redirect_valid;

  assign ir_valid = (count != '0) && !redirect_valid;
  assign pop      = ir_valid && ir_ready;
  assign ir_data  = mem[rd_ptr].dat;
  assign ir_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, dat: imem_rsp_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      rsp_pc      <= redirect_pc;
      rd_ptr      <= wr_ptr;
      count       <= '0;
      // Every in-flight response is now stale; one arriving this cycle retires one of them.
      drop        <= drop + DW'(outstanding) - DW'(imem_rsp_valid);
      outstanding <= '0;
    end else begin
      if (req_fire) pc <= pc + ADDRSIZE'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rsp_pc <= rsp_pc + ADDRSIZE'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(push);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - DW'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: cycle table from reset plus redirect/wrap/halt/reset sequences.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [11:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [11:0] ir_pc;
  logic        redirect_valid;
  logic [11:0] redirect_pc;

  int passed = 0;
  int total  = 0;
  int lat    = 1;
  int ecnt   = 0;
  int n_req  = 0;

  logic [11:0] pend_a[$];
  int          pend_t[$];
  logic [11:0] got_pc[$];
  logic [31:0] got_dat[$];

  typedef struct {
    logic        fen;
    logic        rdy;
    logic        rv;
    logic [11:0] ra;
    logic        iv;
    logic [11:0] ip;
  } vec_t;

  vec_t vt[12];

  always #5 clk = ~clk;

  instr_fetch_queue #(.WIDTH(32), .ADDRSIZE(12), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  function automatic logic [31:0] memv(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  function automatic vec_t mk(input logic fen, input logic rdy, input logic rv,
                              input logic [11:0] ra, input logic iv, input logic [11:0] ip);
    vec_t v;
    v.fen = fen; v.rdy = rdy; v.rv = rv; v.ra = ra; v.iv = iv; v.ip = ip;
    return v;
  endfunction

  // Memory: fixed latency, in order; also logs issued requests and consumed words.
  always @(posedge clk) ecnt++;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_a.delete();
      pend_t.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_a.push_back(imem_req_addr);
        pend_t.push_back(ecnt + 1 + lat);
        n_req++;
      end
      if (ir_valid && ir_ready) begin
        got_pc.push_back(ir_pc);
        got_dat.push_back(ir_data);
      end
      if (pend_t.size() != 0 && pend_t[0] == ecnt + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memv(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      if (imem_rsp_valid && dut.drop == '0 && !redirect_valid && dut.count == DEPTH) begin
        total++;
        $display("FAIL fifo_overflow: response kept with count=%0d, required < %0d", dut.count, DEPTH);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    fetch_en       = 1'b1;
    ir_ready       = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lat = l;
    got_pc.delete();
    got_dat.delete();
    n_req   = 0;
    reset_n = 1'b1;
  endtask

  task automatic chk_stream(input string name, input logic [11:0] first, input int n);
    logic [11:0] e;
    chk($sformatf("%s enough words", name), 32'(got_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < got_pc.size()) begin
        e = first + 12'(i);
        chk($sformatf("%s pc[%0d]", name, i), 32'(got_pc[i]), 32'(e));
        chk($sformatf("%s data[%0d]", name, i), got_dat[i], memv(e));
      end
    end
  endtask

  initial begin
    int old_cnt;

    // Cycle-exact table from reset, 1-cycle memory: fill with ir_ready low, then drain.
    vt[0]  = mk(1'b1, 1'b0, 1'b1, 12'd0, 1'b0, 12'd0);
    vt[1]  = mk(1'b1, 1'b0, 1'b1, 12'd1, 1'b0, 12'd0);
    vt[2]  = mk(1'b1, 1'b0, 1'b1, 12'd2, 1'b1, 12'd0);
    vt[3]  = mk(1'b1, 1'b0, 1'b1, 12'd3, 1'b1, 12'd0);
    vt[4]  = mk(1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 12'd0);
    vt[5]  = mk(1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 12'd0);
    vt[6]  = mk(1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 12'd0);
    vt[7]  = mk(1'b1, 1'b1, 1'b1, 12'd4, 1'b1, 12'd1);
    vt[8]  = mk(1'b1, 1'b1, 1'b1, 12'd5, 1'b1, 12'd2);
    vt[9]  = mk(1'b1, 1'b1, 1'b1, 12'd6, 1'b1, 12'd3);
    vt[10] = mk(1'b1, 1'b1, 1'b1, 12'd7, 1'b1, 12'd4);
    vt[11] = mk(1'b1, 1'b1, 1'b1, 12'd8, 1'b1, 12'd5);

    reset_n        = 1'b1;
    fetch_en       = 1'b1;
    imem_req_ready = 1'b1;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    #1 reset_n = 1'b0;
    #1;
    chk("reset req_valid", imem_req_valid, 32'd0);
    chk("reset ir_valid", ir_valid, 32'd0);

    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      fetch_en = vt[i].fen;
      ir_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d req_valid", i), imem_req_valid, 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("vec%0d req_addr", i), imem_req_addr, 32'(vt[i].ra));
      chk($sformatf("vec%0d ir_valid", i), ir_valid, 32'(vt[i].iv));
      if (vt[i].iv) begin
        chk($sformatf("vec%0d ir_pc", i), ir_pc, 32'(vt[i].ip));
        chk($sformatf("vec%0d ir_data", i), ir_data, memv(vt[i].ip));
      end
      step();
    end

    // Redirect with two requests in flight, 3-cycle memory.
    do_reset(3);
    ir_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h080;
    #1;
    chk("t3 no req in redirect", imem_req_valid, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3 req valid", imem_req_valid, 32'd1);
    chk("t3 req addr", imem_req_addr, 32'h080);
    repeat (25) step();
    chk_stream("t3", 12'h080, 4);
    old_cnt = 0;
    foreach (got_pc[i]) if (got_pc[i] < 12'h080) old_cnt++;
    chk("t3 old words", old_cnt, 32'd0);

    // Back-to-back redirects; a stale response lands in the second redirect cycle.
    do_reset(3);
    ir_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h300;
    #1;
    chk("t3b no req 1", imem_req_valid, 32'd0);
    step();
    redirect_pc = 12'h080;
    #1;
    chk("t3b no req 2", imem_req_valid, 32'd0);
    step();
    redirect_valid = 1'b0;
    repeat (20) step();
    chk_stream("t3b", 12'h080, 4);

    // Redirect coinciding with a pop and a response.
    do_reset(1);
    ir_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h200;
    #1;
    chk("t4 ir_valid masked", ir_valid, 32'd0);
    chk("t4 no req", imem_req_valid, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4 req addr", imem_req_addr, 32'h200);
    step();
    step();
    #1;
    chk("t4 ir_valid T+3", ir_valid, 32'd1);
    chk("t4 ir_pc T+3", ir_pc, 32'h200);
    repeat (6) step();
    chk_stream("t4", 12'h200, 3);

    // PC wrap.
    do_reset(1);
    ir_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFE;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    chk_stream("t5", 12'hFFE, 4);

    // fetch_en low with three in flight, resume with a stalled request, async reset.
    do_reset(3);
    ir_ready = 1'b1;
    step();
    step();
    step();
    fetch_en = 1'b0;
    #1;
    chk("t6 req stop", imem_req_valid, 32'd0);
    repeat (12) step();
    chk("t6 n_req", n_req, 32'd3);
    chk("t6 delivered", got_pc.size(), 32'd3);
    chk_stream("t6", 12'h000, 3);
    chk("t6 drained", ir_valid, 32'd0);

    imem_req_ready = 1'b0;
    ir_ready       = 1'b0;
    fetch_en       = 1'b1;
    #1;
    chk("t6 resume valid", imem_req_valid, 32'd1);
    chk("t6 resume addr", imem_req_addr, 32'h003);
    step();
    #1;
    chk("t6 hold valid", imem_req_valid, 32'd1);
    chk("t6 hold addr", imem_req_addr, 32'h003);
    imem_req_ready = 1'b1;
    repeat (8) step();
    #1;
    chk("t6 pre-reset ir_valid", ir_valid, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6 async req_valid", imem_req_valid, 32'd0);
    chk("t6 async ir_valid", ir_valid, 32'd0);
    do_reset(1);
    ir_ready = 1'b1;
    #1;
    chk("t6 restart valid", imem_req_valid, 32'd1);
    chk("t6 restart addr", imem_req_addr, 32'h000);
    repeat (8) step();
    chk_stream("t6 restart", 12'h000, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
